// File: rtl/ddfs_sweep_controller.sv
// Linear frequency sweep sequencer feeding the DDFS converter freq input.
// Ports: clk, rst_n, start/abort pulses, repeat_en plus sweep config
//    (f_start, f_stop, f_step, dwell) in; freq_out, freq_valid, busy,
//    done, err out (all registered).
module ddfs_sweep_controller #(
   parameter int FREQ_W   = 23,
   parameter int MAX_FREQ = 5000000,
   parameter int DWELL_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               repeat_en,
   input  logic [FREQ_W-1:0]  f_start,
   input  logic [FREQ_W-1:0]  f_stop,
   input  logic [FREQ_W-1:0]  f_step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [FREQ_W-1:0]  freq_out,
   output logic               freq_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_DWELL,
      S_STEP,
      S_DONE
   } state_t;

   localparam logic [FREQ_W:0] MAX_V = (FREQ_W+1)'(MAX_FREQ);

   state_t state_q, state_d;

   logic [FREQ_W-1:0]  start_q, start_d;
   logic [FREQ_W-1:0]  stop_q, stop_d;
   logic [FREQ_W-1:0]  step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               rep_q, rep_d;
   logic               up_q, up_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [FREQ_W-1:0]  freq_q, freq_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [FREQ_W:0]    sum;
   logic [FREQ_W-1:0]  diff;
   logic [FREQ_W-1:0]  up_next;
   logic [FREQ_W-1:0]  dn_next;
   logic               cfg_bad;
   logic [DWELL_W-1:0] reload;

   // Extra sum bit keeps the up step from wrapping near the top of range.
   assign sum     = {1'b0, freq_q} + {1'b0, step_q};
   assign up_next = (sum >= {1'b0, stop_q}) ? stop_q
                                            : sum[FREQ_W-1:0];

   // Down sweeps always sit at or above stop, so diff cannot underflow;
   // comparing it with the step avoids subtracting past stop.
   assign diff    = freq_q - stop_q;
   assign dn_next = (diff <= step_q) ? stop_q : freq_q - step_q;

   assign cfg_bad = ({1'b0, start_q} > MAX_V)
                 || ({1'b0, stop_q} > MAX_V)
                 || (step_q == '0)
                 || (dwell_q == '0);

   assign reload  = dwell_q - DWELL_W'(1);

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      stop_d  = stop_q;
      step_d  = step_q;
      dwell_d = dwell_q;
      rep_d   = rep_q;
      up_d    = up_q;
      cnt_d   = cnt_q;
      freq_d  = freq_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  start_d = f_start;
                  stop_d  = f_stop;
                  step_d  = f_step;
                  dwell_d = dwell;
                  rep_d   = repeat_en;
                  err_d   = 1'b0;
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               if (cfg_bad) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  freq_d  = start_q;
                  valid_d = 1'b1;
                  cnt_d   = reload;
                  up_d    = (stop_q >= start_q);
                  state_d = S_DWELL;
               end
            end
            S_DWELL: begin
               if (cnt_q == '0) begin
                  state_d = S_STEP;
               end else begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end
            end
            S_STEP: begin
               if (freq_q == stop_q) begin
                  if (rep_q) begin
                     freq_d  = start_q;
                     valid_d = 1'b1;
                     cnt_d   = reload;
                     state_d = S_DWELL;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end else begin
                  freq_d  = up_q ? up_next : dn_next;
                  valid_d = 1'b1;
                  cnt_d   = reload;
                  state_d = S_DWELL;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         rep_q   <= 1'b0;
         up_q    <= 1'b0;
         cnt_q   <= '0;
         freq_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         step_q  <= step_d;
         dwell_q <= dwell_d;
         rep_q   <= rep_d;
         up_q    <= up_d;
         cnt_q   <= cnt_d;
         freq_q  <= freq_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign freq_out   = freq_q;
   assign freq_valid = valid_q;
   assign done       = done_q;
   assign err        = err_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ddfs_sweep_controller.sv
// Self-checking bench for ddfs_sweep_controller.
// Observed freq_valid/done events are logged and compared to a sweep model.
module tb_ddfs_sweep_controller;

   localparam int FW   = 23;
   localparam int DW   = 32;
   localparam int MAXF = 5000000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          repeat_en = 1'b0;
   logic [FW-1:0] f_start = '0;
   logic [FW-1:0] f_stop = '0;
   logic [FW-1:0] f_step = '0;
   logic [DW-1:0] dwell = '0;
   logic [FW-1:0] freq_out;
   logic          freq_valid;
   logic          busy;
   logic          done;
   logic          err;

   ddfs_sweep_controller #(
      .FREQ_W(FW),
      .MAX_FREQ(MAXF),
      .DWELL_W(DW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .repeat_en(repeat_en),
      .f_start(f_start),
      .f_stop(f_stop),
      .f_step(f_step),
      .dwell(dwell),
      .freq_out(freq_out),
      .freq_valid(freq_valid),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   int v_cyc[$];
   int v_val[$];
   int d_cyc[$];
   int exp_val[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (freq_valid) begin
            v_cyc.push_back(cyc);
            v_val.push_back(int'(freq_out));
         end
         if (done) d_cyc.push_back(cyc);
      end
   end

   // Sweep values: start, then step toward stop, clamped at stop.
   function automatic void build_model(input int s, input int e,
                                       input int st);
      longint v;
      exp_val.delete();
      v = s;
      exp_val.push_back(int'(v));
      while (v != e) begin
         if (e >= s) v = (v + st > e) ? longint'(e) : v + st;
         else        v = (v - st < e) ? longint'(e) : v - st;
         exp_val.push_back(int'(v));
      end
   endfunction

   task automatic clear_logs();
      v_cyc.delete();
      v_val.delete();
      d_cyc.delete();
   endtask

   task automatic set_cfg(input int s, input int e, input int st,
                          input int dw, input logic rep);
      f_start   = FW'(s);
      f_stop    = FW'(e);
      f_step    = FW'(st);
      dwell     = DW'(dw);
      repeat_en = rep;
   endtask

   // Returns the edge number at which start is sampled.
   task automatic pulse_start(output int e);
      @(negedge clk);
      start = 1'b1;
      e = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic scramble_inputs();
      f_start   = FW'($urandom);
      f_stop    = FW'($urandom);
      f_step    = FW'($urandom_range(0, 3));
      dwell     = DW'($urandom_range(0, 2));
      repeat_en = 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if ({freq_out, freq_valid, busy, done, err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h required 0",
                  {freq_out, freq_valid, busy, done, err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || freq_valid !== 1'b0 || freq_out !== '0) begin
         failures++;
         $display("FAIL reset_release: busy=%b valid=%b freq=%0d required 0",
                  busy, freq_valid, freq_out);
      end
   endtask

   task automatic test_sweep_cfg(input string name, input int s,
                                 input int e, input int st, input int dw);
      int t;
      int n;
      int total;
      int last;
      set_cfg(s, e, st, dw, 1'b0);
      build_model(s, e, st);
      n = exp_val.size();
      clear_logs();
      pulse_start(t);
      scramble_inputs();
      total = 1 + n * (dw + 1) + 3;
      repeat (total) @(negedge clk);
      checks++;
      if (v_val.size() != n) begin
         failures++;
         $display("FAIL %s_count: got %0d values required %0d",
                  name, v_val.size(), n);
      end
      for (int i = 0; i < n && i < v_val.size(); i++) begin
         checks++;
         if (v_val[i] != exp_val[i] || v_cyc[i] != t + 1 + i * (dw + 1)) begin
            failures++;
            $display("FAIL %s_value[%0d]: got %0d@%0d required %0d@%0d",
                     name, i, v_val[i], v_cyc[i], exp_val[i],
                     t + 1 + i * (dw + 1));
         end
      end
      last = t + 1 + n * (dw + 1);
      checks++;
      if (d_cyc.size() != 1 || (d_cyc.size() == 1 && d_cyc[0] != last)) begin
         failures++;
         $display("FAIL %s_done: got %0d pulses first@%0d required 1@%0d",
                  name, d_cyc.size(),
                  (d_cyc.size() > 0) ? d_cyc[0] : -1, last);
      end
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || int'(freq_out) != exp_val[n-1])
      begin
         failures++;
         $display("FAIL %s_end: err=%b busy=%b freq=%0d required 0 0 %0d",
                  name, err, busy, freq_out, exp_val[n-1]);
      end
   endtask

   task automatic test_up();
      test_sweep_cfg("up", 1000, 1300, 100, 4);
   endtask

   task automatic test_clamp_down();
      test_sweep_cfg("clamp_up", 0, 250, 100, 3);
      test_sweep_cfg("clamp_down", 5000000, 4999750, 100, 2);
      test_sweep_cfg("degenerate", 700, 700, 5, 1);
   endtask

   task automatic test_random();
      int s;
      int st;
      int dw;
      longint e;
      for (int k = 0; k < 10; k++) begin
         s  = int'($urandom_range(0, MAXF));
         st = int'($urandom_range(1, 2000));
         dw = int'($urandom_range(1, 5));
         e  = longint'($urandom_range(0, 6)) * st
            + longint'($urandom_range(0, st - 1));
         e  = ($urandom_range(0, 1) == 1) ? s + e : s - e;
         if (e < 0) e = 0;
         if (e > MAXF) e = MAXF;
         test_sweep_cfg("random", s, int'(e), st, dw);
      end
   endtask

   task automatic test_errors();
      int t;
      int cfg[3][4];
      logic [FW-1:0] f0;
      cfg[0] = '{1000, 1300, 0, 4};
      cfg[1] = '{1000, 1300, 100, 0};
      cfg[2] = '{1000, 5000001, 100, 4};
      for (int k = 0; k < 3; k++) begin
         set_cfg(cfg[k][0], cfg[k][1], cfg[k][2], cfg[k][3], 1'b0);
         f0 = freq_out;
         clear_logs();
         pulse_start(t);
         @(negedge clk);
         checks++;
         if (err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_case%0d: err=%b busy=%b required 1 0",
                     k, err, busy);
         end
         repeat (6) @(negedge clk);
         checks++;
         if (v_val.size() != 0 || d_cyc.size() != 0 || freq_out !== f0) begin
            failures++;
            $display("FAIL err_quiet%0d: valids=%0d dones=%0d freq=%0d required 0 0 %0d",
                     k, v_val.size(), d_cyc.size(), freq_out, f0);
         end
      end
      set_cfg(700, 700, 1, 1, 1'b0);
      pulse_start(t);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL err_clear: err=%b busy=%b required 0 1", err, busy);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_abort();
      int t;
      set_cfg(1000, 1300, 100, 4, 1'b0);
      clear_logs();
      pulse_start(t);
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || freq_out !== FW'(1100)) begin
         failures++;
         $display("FAIL abort_now: busy=%b freq=%0d required 0 1100",
                  busy, freq_out);
      end
      repeat (15) @(negedge clk);
      checks++;
      if (v_val.size() != 2 || d_cyc.size() != 0 || freq_out !== FW'(1100)
          || err !== 1'b0) begin
         failures++;
         $display("FAIL abort_after: valids=%0d dones=%0d freq=%0d err=%b required 2 0 1100 0",
                  v_val.size(), d_cyc.size(), freq_out, err);
      end
   endtask

   task automatic test_start_abort_same();
      set_cfg(10, 20, 5, 1, 1'b0);
      clear_logs();
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL start_abort_busy: got %b required 0", busy);
      end
      repeat (6) @(negedge clk);
      checks++;
      if (v_val.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL start_abort_quiet: valids=%0d busy=%b required 0 0",
                  v_val.size(), busy);
      end
   endtask

   task automatic test_start_busy();
      int t;
      int t2;
      set_cfg(1000, 1300, 100, 4, 1'b0);
      build_model(1000, 1300, 100);
      clear_logs();
      pulse_start(t);
      set_cfg(0, 50, 10, 1, 1'b0);
      repeat (3) @(negedge clk);
      pulse_start(t2);
      repeat (22) @(negedge clk);
      checks++;
      if (v_val.size() != exp_val.size() || d_cyc.size() != 1) begin
         failures++;
         $display("FAIL busy_start_count: valids=%0d dones=%0d required %0d 1",
                  v_val.size(), d_cyc.size(), exp_val.size());
      end
      for (int i = 0; i < exp_val.size() && i < v_val.size(); i++) begin
         checks++;
         if (v_val[i] != exp_val[i]) begin
            failures++;
            $display("FAIL busy_start_value[%0d]: got %0d required %0d",
                     i, v_val[i], exp_val[i]);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_start_end: busy=%b required 0", busy);
      end
   endtask

   task automatic test_repeat();
      int t;
      int n;
      set_cfg(1000, 1200, 100, 2, 1'b1);
      build_model(1000, 1200, 100);
      clear_logs();
      pulse_start(t);
      repeat_en = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (v_val.size() != 10 || d_cyc.size() != 0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL repeat_count: valids=%0d dones=%0d busy=%b required 10 0 1",
                  v_val.size(), d_cyc.size(), busy);
      end
      n = exp_val.size();
      for (int i = 0; i < v_val.size(); i++) begin
         checks++;
         if (v_val[i] != exp_val[i % n] || v_cyc[i] != t + 1 + 3 * i) begin
            failures++;
            $display("FAIL repeat_value[%0d]: got %0d@%0d required %0d@%0d",
                     i, v_val[i], v_cyc[i], exp_val[i % n], t + 1 + 3 * i);
         end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      int t;
      set_cfg(1000, 1300, 100, 4, 1'b0);
      clear_logs();
      pulse_start(t);
      repeat (8) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({freq_out, freq_valid, busy, done, err} !== '0) begin
         failures++;
         $display("FAIL async_reset: got %h required 0",
                  {freq_out, freq_valid, busy, done, err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      repeat (8) @(negedge clk);
      checks++;
      if (v_val.size() != 0 || d_cyc.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_release: valids=%0d dones=%0d busy=%b required 0 0 0",
                  v_val.size(), d_cyc.size(), busy);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      test_up();
      test_clamp_down();
      test_errors();
      test_abort();
      test_start_abort_same();
      test_start_busy();
      test_repeat();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
